// File: rtl/ili9341_pkg.sv
// Shared types for the ILI9341 command scheduler: ROM opcodes, FSM states
// and bit positions of the fields inside a command ROM word.
package ili9341_pkg;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } rom_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LO,
    S_RST_REC,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT
  } state_e;

  localparam int unsigned ROM_OP_HI  = 15;
  localparam int unsigned ROM_OP_LO  = 14;
  localparam int unsigned ROM_ARG_HI = 7;
  localparam int unsigned ROM_ARG_LO = 0;

endpackage

// File: rtl/ili9341_ms_timer.sv
// Loadable millisecond down-counter. A load of N ms makes done_o rise after
// exactly N*CLKS_PER_MS cycles (counter loaded with N*CLKS_PER_MS-1).
module ili9341_ms_timer #(
  parameter int unsigned CLKS_PER_MS = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] ms_i,
  output logic       done_o
);

  localparam int unsigned    CW     = $clog2(255 * CLKS_PER_MS);
  localparam logic [CW-1:0]  CLKS_C = CW'(CLKS_PER_MS);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: load takes priority, otherwise count down and park at zero.
  // The scale factor is a constant, so the product is a constant-coefficient
  // shift/add network rather than a general multiplier.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(ms_i) * CLKS_C - CW'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ili9341_cmd_sched.sv
// ILI9341 command scheduler: runs the power-on init program from the command
// ROM (hardware reset pulse, ms delays, command/data bytes) and otherwise
// passes host bytes through to the single bus-engine write port.
module ili9341_cmd_sched
  import ili9341_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS      = 100000,
  parameter int unsigned RESET_MS         = 10,
  parameter int unsigned RESET_RECOVER_MS = 120,
  parameter int unsigned ROM_AW           = 6
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start_init,
  input  logic              host_valid,
  input  logic              host_dc,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              bus_valid,
  output logic              bus_dc,
  output logic [7:0]        bus_data,
  input  logic              bus_ready,
  output logic              lcd_rst_n,
  output logic              init_busy,
  output logic              init_done
);

  state_e            state_q, state_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_dc_q, bus_dc_d;
  logic [7:0]        bus_data_q, bus_data_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              rst_n_q, rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;

  logic              host_rdy;
  logic              tmr_load;
  logic [7:0]        tmr_ms;
  logic              tmr_done;
  logic              advance;
  logic              finish;

  rom_op_e           rom_op;
  logic [7:0]        rom_arg;
  logic              rom_rsvd_unused;

  assign rom_op          = rom_op_e'(rom_data[ROM_OP_HI:ROM_OP_LO]);
  assign rom_arg         = rom_data[ROM_ARG_HI:ROM_ARG_LO];
  assign rom_rsvd_unused = ^rom_data[ROM_OP_LO-1:ROM_ARG_HI+1];

  ili9341_ms_timer #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_timer (
    .clk_i (ACLK),
    .rst_i (ARESET),
    .load_i(tmr_load),
    .ms_i  (tmr_ms),
    .done_o(tmr_done)
  );

  // Next-state and output-register logic for host pass-through and init program.
  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_dc_d    = bus_dc_q;
    bus_data_d  = bus_data_q;
    rom_addr_d  = rom_addr_q;
    rst_n_d     = rst_n_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pend_d      = pend_q;
    host_rdy    = 1'b0;
    tmr_load    = 1'b0;
    tmr_ms      = '0;
    advance     = 1'b0;
    finish      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_init || pend_q) begin
          // A host byte still on the bus must drain before the reset pulse.
          if (!bus_valid_q) begin
            state_d  = S_RST_LO;
            rst_n_d  = 1'b0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            pend_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_ms   = 8'(RESET_MS);
          end else begin
            pend_d = 1'b1;
            if (bus_ready) bus_valid_d = 1'b0;
          end
        end else begin
          host_rdy = (!bus_valid_q || bus_ready) && !ARESET;
          if (bus_valid_q && bus_ready) bus_valid_d = 1'b0;
          if (host_valid && host_rdy) begin
            bus_valid_d = 1'b1;
            bus_dc_d    = host_dc;
            bus_data_d  = host_data;
          end
        end
      end
      S_RST_LO: begin
        if (tmr_done) begin
          state_d  = S_RST_REC;
          rst_n_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_ms   = 8'(RESET_RECOVER_MS);
        end
      end
      S_RST_REC: begin
        if (tmr_done) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (rom_op)
          OP_CMD, OP_DATA: begin
            bus_valid_d = 1'b1;
            bus_dc_d    = (rom_op == OP_DATA);
            bus_data_d  = rom_arg;
            state_d     = S_SEND;
          end
          OP_DELAY: begin
            if (rom_arg != '0) begin
              tmr_load = 1'b1;
              tmr_ms   = rom_arg;
              state_d  = S_WAIT;
            end else begin
              advance = 1'b1;
            end
          end
          OP_END: finish = 1'b1;
          default: finish = 1'b1;
        endcase
      end
      S_SEND: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          advance     = 1'b1;
        end
      end
      S_WAIT: begin
        if (tmr_done) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The last ROM word ends the program even without an END opcode.
    if (advance) begin
      if (rom_addr_q == '1) begin
        finish = 1'b1;
      end else begin
        rom_addr_d = rom_addr_q + ROM_AW'(1);
        state_d    = S_FETCH;
      end
    end
    if (finish) begin
      busy_d  = 1'b0;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      bus_valid_q <= 1'b0;
      bus_dc_q    <= 1'b0;
      bus_data_q  <= '0;
      rom_addr_q  <= '0;
      rst_n_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_dc_q    <= bus_dc_d;
      bus_data_q  <= bus_data_d;
      rom_addr_q  <= rom_addr_d;
      rst_n_q     <= rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
    end
  end

  assign host_ready = host_rdy;
  assign rom_addr   = rom_addr_q;
  assign bus_valid  = bus_valid_q;
  assign bus_dc     = bus_dc_q;
  assign bus_data   = bus_data_q;
  assign lcd_rst_n  = rst_n_q;
  assign init_busy  = busy_q;
  assign init_done  = done_q;

endmodule

// File: tb/tb_ili9341_cmd_sched.sv
// Scoreboard bench for ili9341_cmd_sched: stimulus pushes expected bus bytes,
// a negedge monitor pops and compares every bus handshake.
module tb_ili9341_cmd_sched;

  localparam int CLKS = 4;
  localparam int RMS  = 2;
  localparam int RRMS = 3;
  localparam int AW   = 6;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          start_init = 1'b0;
  logic          host_valid = 1'b0;
  logic          host_dc = 1'b0;
  logic [7:0]    host_data = '0;
  logic          host_ready;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0;
  logic          bus_valid;
  logic          bus_dc;
  logic [7:0]    bus_data;
  logic          bus_ready = 1'b1;
  logic          lcd_rst_n;
  logic          init_busy;
  logic          init_done;

  ili9341_cmd_sched #(
    .CLKS_PER_MS(CLKS),
    .RESET_MS(RMS),
    .RESET_RECOVER_MS(RRMS),
    .ROM_AW(AW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start_init(start_init),
    .host_valid(host_valid), .host_dc(host_dc), .host_data(host_data),
    .host_ready(host_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .bus_valid(bus_valid), .bus_dc(bus_dc), .bus_data(bus_data),
    .bus_ready(bus_ready), .lcd_rst_n(lcd_rst_n), .init_busy(init_busy),
    .init_done(init_done)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Command ROM with one cycle read latency.
  logic [15:0] rom [64];
  always @(posedge ACLK) rom_data <= rom[rom_addr];

  // bus_ready driver: 0 = always ready, 1 = random, 2 = stalled.
  int rdy_mode = 0;
  always @(posedge ACLK) begin
    #1;
    case (rdy_mode)
      0:       bus_ready = 1'b1;
      1:       bus_ready = ($urandom % 4) != 0;
      default: bus_ready = 1'b0;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       dc;
    logic [7:0] data;
    int         t;
  } exp_t;
  exp_t sb[$];

  bit         prev_stall = 1'b0;
  logic [8:0] prev_word = '0;

  // Monitor: compare each accepted bus byte against the scoreboard head,
  // check that stalled bytes stay put, and that hosts are blocked during init.
  always @(negedge ACLK) begin
    exp_t e;
    if (!ARESET) begin
      if (prev_stall) begin
        check("hold_valid", bus_valid, 1'b1);
        check("hold_word", {bus_dc, bus_data}, prev_word);
      end
      if (init_busy) check("host_ready_in_init", host_ready, 1'b0);
      if (bus_valid && bus_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_bus_xfer: got dc=%0d data=0x%0h expected no transfer (cycle %0d)",
                   bus_dc, bus_data, cyc);
        end else begin
          e = sb.pop_front();
          check("bus_dc", bus_dc, e.dc);
          check("bus_data", bus_data, e.data);
          if (e.t >= 0) check("bus_time", cyc, e.t);
        end
      end
    end
    prev_stall = bus_valid && !bus_ready && !ARESET;
    prev_word  = {bus_dc, bus_data};
  end

  function automatic logic [15:0] w_cmd(input logic [7:0] a);   return {2'b00, 6'd0, a}; endfunction
  function automatic logic [15:0] w_data(input logic [7:0] a);  return {2'b01, 6'd0, a}; endfunction
  function automatic logic [15:0] w_delay(input logic [7:0] a); return {2'b10, 6'd0, a}; endfunction
  function automatic logic [15:0] w_end();                      return {2'b11, 14'd0};   endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = w_end();
  endtask

  // Reference model: walk the ROM as the program would and predict every bus
  // byte. With an always-ready bus each word costs FETCH+DECODE plus one SEND
  // cycle (CMD/DATA) or n ms of waiting (DELAY n); the first FETCH follows the
  // reset pulse and recovery time.
  task automatic build_expect(input int s, input bit timed);
    int          t;
    logic [15:0] w;
    logic [1:0]  op;
    exp_t        e;
    t = s + (RMS + RRMS) * CLKS;
    for (int i = 0; i < 64; i++) begin
      w  = rom[i];
      op = w[15:14];
      if (op == 2'b11) break;
      if (op == 2'b10) begin
        t += 2 + int'(w[7:0]) * CLKS;
      end else begin
        e.dc   = (op == 2'b01);
        e.data = w[7:0];
        e.t    = timed ? t + 2 : -1;
        sb.push_back(e);
        t += 3;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bus_valid"}, bus_valid, 1'b0);
    check({tag, "_bus_dc"}, bus_dc, 1'b0);
    check({tag, "_bus_data"}, bus_data, 8'h00);
    check({tag, "_host_ready"}, host_ready, 1'b0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_lcd_rst_n"}, lcd_rst_n, 1'b1);
    check({tag, "_init_busy"}, init_busy, 1'b0);
    check({tag, "_init_done"}, init_done, 1'b0);
  endtask

  task automatic pulse_start(input bit collide, output int s);
    @(posedge ACLK); #1;
    start_init = 1'b1;
    if (collide) begin
      host_valid = 1'b1; host_dc = 1'b1; host_data = 8'hEE;
    end
    @(negedge ACLK);
    if (collide) check("collide_host_ready", host_ready, 1'b0);
    @(posedge ACLK); #1;
    start_init = 1'b0;
    host_valid = 1'b0;
    s = cyc;
  endtask

  task automatic chk_rst_pulse();
    int lo = 0;
    bit busy_ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge ACLK);
      if (!lcd_rst_n) begin
        lo++;
        if (!init_busy) busy_ok = 1'b0;
      end else if (lo > 0) begin
        break;
      end
    end
    check("rst_lo_cycles", lo, RMS * CLKS);
    check("busy_during_rst", busy_ok, 1'b1);
    check("done_cleared", init_done, 1'b0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge ACLK);
      if (init_done) break;
    end
    check("init_done", init_done, 1'b1);
    check("init_busy_clear", init_busy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || bus_valid); i++) @(negedge ACLK);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic apply_areset(input string tag);
    @(posedge ACLK); #1 ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset_vals(tag);
    @(posedge ACLK); #1 ARESET = 1'b0;
  endtask

  initial begin
    int s;
    clear_rom();

    // Reset values.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_vals("reset");
    @(posedge ACLK); #1 ARESET = 1'b0;

    // Init program with timing and an always-ready bus.
    clear_rom();
    rom[0] = w_cmd(8'h01); rom[1] = w_delay(8'd2); rom[2] = w_cmd(8'h11);
    rom[3] = w_data(8'h55); rom[4] = w_end();
    rdy_mode = 0;
    pulse_start(1'b0, s);
    build_expect(s, 1'b1);
    chk_rst_pulse();
    wait_done();
    drain();

    // Backpressure on a single command.
    clear_rom();
    rom[0] = w_cmd(8'h29);
    rdy_mode = 2;
    pulse_start(1'b0, s);
    build_expect(s, 1'b0);
    for (int i = 0; i < 100 && !bus_valid; i++) @(negedge ACLK);
    repeat (10) begin
      @(negedge ACLK);
      check("bp_valid", bus_valid, 1'b1);
      check("bp_data", bus_data, 8'h29);
      check("bp_rom_addr", rom_addr, 0);
    end
    rdy_mode = 0;
    wait_done();
    check("bp_rom_addr_after", rom_addr, 1);
    drain();

    // Back-to-back host stream.
    begin
      logic [7:0] hb [4];
      logic       hd [4];
      exp_t       e;
      hb[0] = 8'h2C; hb[1] = 8'hAA; hb[2] = 8'hBB; hb[3] = 8'hCC;
      hd[0] = 1'b0;  hd[1] = 1'b1;  hd[2] = 1'b1;  hd[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(posedge ACLK); #1;
        host_valid = 1'b1; host_dc = hd[k]; host_data = hb[k];
        e.dc = hd[k]; e.data = hb[k]; e.t = cyc + 1;
        sb.push_back(e);
        @(negedge ACLK);
        check("stream_host_ready", host_ready, 1'b1);
      end
      @(posedge ACLK); #1 host_valid = 1'b0;
      drain();
    end

    // Random host traffic against random backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 60; k++) begin
      exp_t e;
      @(posedge ACLK); #1;
      host_valid = ($urandom % 3) != 0;
      host_dc    = 1'($urandom);
      host_data  = 8'($urandom);
      @(negedge ACLK);
      if (host_valid && host_ready) begin
        e.dc = host_dc; e.data = host_data; e.t = -1;
        sb.push_back(e);
      end
    end
    @(posedge ACLK); #1 host_valid = 1'b0;
    drain();

    // Collision with a host byte, plus a restart attempt mid-init.
    clear_rom();
    begin
      int n = $urandom_range(3, 10);
      for (int i = 0; i < n; i++) begin
        case ($urandom % 3)
          0:       rom[i] = w_cmd(8'($urandom));
          1:       rom[i] = w_data(8'($urandom));
          default: rom[i] = w_delay(8'($urandom % 3));
        endcase
      end
    end
    pulse_start(1'b1, s);
    build_expect(s, 1'b0);
    chk_rst_pulse();
    @(posedge ACLK); #1 start_init = 1'b1;
    @(posedge ACLK); #1 start_init = 1'b0;
    @(negedge ACLK);
    check("restart_ignored_rst_n", lcd_rst_n, 1'b1);
    check("restart_ignored_busy", init_busy, 1'b1);
    wait_done();
    drain();

    // start_init while a host byte is stalled on the bus is deferred.
    clear_rom();
    rom[0] = w_cmd(8'h01); rom[1] = w_data(8'h42);
    rdy_mode = 2;
    begin
      exp_t e;
      @(posedge ACLK); #1;
      host_valid = 1'b1; host_dc = 1'b0; host_data = 8'h77;
      @(negedge ACLK);
      check("pend_host_ready", host_ready, 1'b1);
      e.dc = 1'b0; e.data = 8'h77; e.t = -1;
      sb.push_back(e);
    end
    @(posedge ACLK); #1 host_valid = 1'b0; start_init = 1'b1;
    @(posedge ACLK); #1 start_init = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      check("pend_rst_n", lcd_rst_n, 1'b1);
      check("pend_busy", init_busy, 1'b0);
    end
    build_expect(0, 1'b0);
    rdy_mode = 0;
    chk_rst_pulse();
    wait_done();
    drain();

    // ARESET while waiting on a delay.
    clear_rom();
    rom[0] = w_delay(8'd5);
    pulse_start(1'b0, s);
    for (int i = 0; i < 100 && cyc < s + 25; i++) @(negedge ACLK);
    check("wait_busy_before_reset", init_busy, 1'b1);
    apply_areset("areset_wait");

    // ARESET while a ROM byte is stalled in SEND; the byte is dropped.
    clear_rom();
    rom[0] = w_cmd(8'h3A);
    rdy_mode = 2;
    pulse_start(1'b0, s);
    for (int i = 0; i < 100 && !bus_valid; i++) @(negedge ACLK);
    check("send_valid_before_reset", bus_valid, 1'b1);
    apply_areset("areset_send");
    rdy_mode = 0;
    repeat (3) @(negedge ACLK);
    check("areset_send_no_resend", bus_valid, 1'b0);

    // ROM with no END: stops after the last word.
    for (int i = 0; i < 64; i++) rom[i] = w_data(8'(i * 3 + 1));
    rdy_mode = 1;
    pulse_start(1'b0, s);
    build_expect(s, 1'b0);
    chk_rst_pulse();
    wait_done();
    check("noend_rom_addr", rom_addr, 63);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, expected completion before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
